// File: rtl/lsu_mem_access.sv
// Load/store unit: one data-RAM access per request, lane steering and load extension.
// Optional LSU_MISALIGN_TRAP_EN: flag misaligned accesses instead of forcing alignment.
module lsu_mem_access #(
    parameter int RD_LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        is_load,
    input  logic        is_store,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [1:0]  read_size,
    input  logic [1:0]  write_size,
    input  logic        read_signed,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
`ifdef LSU_MISALIGN_TRAP_EN
    output logic        misalign,
`endif
    output logic [31:0] mem_addr,
    output logic        mem_re,
    output logic [3:0]  mem_we,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    localparam logic [1:0] RAM_MODE_NONE = 2'd0;
    localparam logic [1:0] RAM_MODE_BYTE = 2'd1;
    localparam logic [1:0] RAM_MODE_HALF = 2'd2;
    localparam logic [1:0] RAM_MODE_WORD = 2'd3;

    localparam logic [2:0] LAT_M1 = 3'(RD_LATENCY - 1);

    typedef enum logic [2:0] {
        IDLE,
        WR,
        RD_ISSUE,
        RD_WAIT,
        RESP
    } state_t;

    state_t      state_q, state_n;
    logic [2:0]  cnt_q, cnt_n;
    logic [1:0]  off_q, off_n;
    logic [1:0]  rsize_q, rsize_n;
    logic        sgn_q, sgn_n;
    logic [31:0] maddr_n;
    logic [3:0]  we_n;
    logic [31:0] wd_n;
    logic [31:0] rdata_n;
    logic        do_load, do_store, trap;
    logic [1:0]  sz, o_eff;
`ifdef LSU_MISALIGN_TRAP_EN
    logic        mis_q, mis_n;
`endif

    function automatic logic [31:0] load_ext(
        input logic [31:0] d,
        input logic [1:0]  o,
        input logic [1:0]  size,
        input logic        sg
    );
        logic [31:0] s;
        s = d >> {o, 3'b000};
        case (size)
            RAM_MODE_BYTE: load_ext = {{24{sg & s[7]}}, s[7:0]};
            RAM_MODE_HALF: load_ext = {{16{sg & s[15]}}, s[15:0]};
            default:       load_ext = d;
        endcase
    endfunction

    assign do_load  = is_load && !is_store && (read_size != RAM_MODE_NONE);
    assign do_store = is_store && !is_load && (write_size != RAM_MODE_NONE);
    assign sz       = do_load ? read_size : write_size;

    // Effective byte offset and misalignment decision for the incoming request
    always_comb begin
        o_eff = addr[1:0];
        trap  = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
        if (do_load || do_store) begin
            trap = ((sz == RAM_MODE_HALF) && addr[0]) ||
                   ((sz == RAM_MODE_WORD) && (addr[1:0] != 2'b00));
        end
`else
        if (sz == RAM_MODE_HALF) begin
            o_eff = {addr[1], 1'b0};
        end else if (sz == RAM_MODE_WORD) begin
            o_eff = 2'b00;
        end
`endif
    end

    // Next-state, captured request fields and next output values
    always_comb begin
        state_n = state_q;
        cnt_n   = cnt_q;
        off_n   = off_q;
        rsize_n = rsize_q;
        sgn_n   = sgn_q;
        maddr_n = mem_addr;
        we_n    = '0;
        wd_n    = '0;
        rdata_n = '0;
`ifdef LSU_MISALIGN_TRAP_EN
        mis_n   = mis_q;
`endif
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    maddr_n = {addr[31:2], 2'b00};
                    off_n   = o_eff;
                    rsize_n = read_size;
                    sgn_n   = read_signed;
                    cnt_n   = '0;
`ifdef LSU_MISALIGN_TRAP_EN
                    mis_n   = trap;
`endif
                    unique case (1'b1)
                        trap: state_n = RESP;
                        do_store && !trap: begin
                            state_n = WR;
                            case (write_size)
                                RAM_MODE_BYTE: begin
                                    we_n = 4'b0001 << o_eff;
                                    wd_n = {4{wdata[7:0]}};
                                end
                                RAM_MODE_HALF: begin
                                    we_n = 4'b0011 << o_eff;
                                    wd_n = {2{wdata[15:0]}};
                                end
                                default: begin
                                    we_n = 4'b1111;
                                    wd_n = wdata;
                                end
                            endcase
                        end
                        do_load && !trap: state_n = RD_ISSUE;
                        default: state_n = RESP;
                    endcase
                end
            end
            WR:       state_n = IDLE;
            RD_ISSUE: begin
                state_n = RD_WAIT;
                cnt_n   = '0;
            end
            RD_WAIT: begin
                if (cnt_q == LAT_M1) begin
                    state_n = RESP;
                    rdata_n = load_ext(mem_rdata, off_q, rsize_q, sgn_q);
                end else begin
                    cnt_n = cnt_q + 3'd1;
                end
            end
            RESP:     state_n = IDLE;
            default:  state_n = IDLE;
        endcase
    end

    // State register and captured request fields
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            off_q   <= '0;
            rsize_q <= RAM_MODE_NONE;
            sgn_q   <= 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
            mis_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_n;
            cnt_q   <= cnt_n;
            off_q   <= off_n;
            rsize_q <= rsize_n;
            sgn_q   <= sgn_n;
`ifdef LSU_MISALIGN_TRAP_EN
            mis_q   <= mis_n;
`endif
        end
    end

    // Registered outputs decoded from the upcoming state
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            mem_addr  <= '0;
            mem_re    <= 1'b0;
            mem_we    <= '0;
            mem_wdata <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
            misalign  <= 1'b0;
`endif
        end else begin
            req_ready <= (state_n == IDLE);
            rsp_valid <= (state_n == WR) || (state_n == RESP);
            rsp_rdata <= rdata_n;
            mem_addr  <= (state_n == IDLE) ? '0 : maddr_n;
            mem_re    <= (state_n == RD_ISSUE);
            mem_we    <= (state_n == WR) ? we_n : '0;
            mem_wdata <= (state_n == WR) ? wd_n : '0;
`ifdef LSU_MISALIGN_TRAP_EN
            misalign  <= (state_n == RESP) && mis_n;
`endif
        end
    end

endmodule

// File: doc/lsu_mem_access.md
Name: lsu_mem_access

Overview:
- Load/store unit directly downstream of the instruction decoder.
- Consumes the decoder's is_load, is_store, ram_read_size, ram_write_size and ram_read_signed, together with the ALU-computed byte address and rs2 store data.
- Performs the single data-RAM access with little-endian byte-lane steering and load sign/zero extension.
- Returns a response to the writeback stage through a valid/ready request and a one-cycle response pulse.

Parameters:
- RD_LATENCY, 1: cycles from the mem_re cycle to the cycle mem_rdata is valid. Range 1..7.

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  synchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  unit can accept; high only in IDLE
- is_load  in  1  load request
- is_store  in  1  store request
- addr  in  32  byte address
- wdata  in  32  store data, low bits significant
- read_size  in  2  RAM_MODE_NONE/BYTE/HALF/WORD, from the shared defines
- write_size  in  2  same encoding
- read_signed  in  1  1 = sign-extend loads
- rsp_valid  out  1  one-cycle completion pulse
- rsp_rdata  out  32  extended load data; 0 for non-loads
- misalign  out  1  misaligned-access flag, valid with rsp_valid; present only with the optional feature
- mem_addr  out  32  word-aligned address, {addr[31:2],2'b00}
- mem_re  out  1  read strobe, one cycle
- mem_we  out  4  byte write enables, one cycle
- mem_wdata  out  32  lane-replicated store data
- mem_rdata  in  32  RAM read data

Behaviour:
- Reset (rst_n=0 at a rising edge): state←IDLE. All outputs 0 except req_ready=1. Latency counter cleared.
- Reset asserted mid-operation aborts: no pending mem_re or mem_we is issued afterwards, and no rsp_valid is produced.
- State machine states: IDLE, WR, RD_ISSUE, RD_WAIT, RESP.
- Accept: req_valid && req_ready in cycle T. All request fields are registered at T.
- Store (is_store=1, write_size≠NONE): T+1 is state WR.
  - mem_we and mem_wdata are driven for exactly that one cycle.
  - rsp_valid=1 in the same cycle with rsp_rdata=0.
  - Returns to IDLE at T+2.
- Load (is_load=1, read_size≠NONE): T+1 is RD_ISSUE, with mem_re=1 and mem_addr driven.
  - RD_WAIT counts RD_LATENCY−1 further cycles.
  - mem_rdata is sampled at T+1+RD_LATENCY.
  - RESP at T+2+RD_LATENCY: rsp_valid=1 with registered rsp_rdata.
  - IDLE the following cycle.
- No-op cases: neither flag set, both flags set, or size=NONE. RESP at T+1 with rsp_rdata=0, no mem strobes.
- req_ready=0 in every state except IDLE; back-to-back requests are therefore separated by at least one cycle.
- mem_addr holds its value from RD_ISSUE/WR through RESP and is 0 in IDLE.
- Store lanes, with o = addr[1:0]:
  - BYTE: mem_we=4'b0001<<o, mem_wdata={4{wdata[7:0]}}.
  - HALF: mem_we=4'b0011<<o, mem_wdata={2{wdata[15:0]}}.
  - WORD: mem_we=4'b1111, mem_wdata=wdata.
- Load extract: s = mem_rdata >> (8*o).
  - BYTE: 8-bit s[7:0] extended.
  - HALF: s[15:0] extended.
  - WORD: mem_rdata unchanged.
  - Extension is sign if read_signed=1, else zero.
- Misaligned access: HALF with addr[0]=1, or WORD with addr[1:0]≠0. Handling depends on the optional feature.
- Outputs are registered. Combinational paths from req_* to mem_* are forbidden.

Optional Feature:
- Macro: LSU_MISALIGN_TRAP_EN.
- With the macro defined:
  - The misalign port exists.
  - A misaligned request goes to RESP at T+1 with misalign=1 and rsp_rdata=0.
  - No mem_re or mem_we is issued.
  - misalign is 0 for all other responses and 0 when rsp_valid=0.
- Without the macro:
  - No misalign port.
  - Misaligned offsets are forced aligned: HALF uses o&2'b10, WORD uses o=0.
  - The access proceeds normally.

Test Plan:
- Reset mid-load: accept LW at 0x10, assert rst_n=0 during RD_WAIT → no rsp_valid, req_ready=1 after reset, mem_re=0.
- SB addr=0x0000_0103, wdata=0xAABB_CCDD → T+1: mem_we=4'b1000, mem_wdata=0xDDDD_DDDD, mem_addr=0x100, rsp_valid=1.
- LB signed and LBU at addr 0x102, mem_rdata=0x1280_FF34, RD_LATENCY=1:
  - LB → rsp at T+3, rsp_rdata=0xFFFF_FF80.
  - LBU → 0x0000_0080.
- LH at 0x202, mem_rdata=0x8001_1234, RD_LATENCY=3 → mem_re at T+1, rsp at T+5, rsp_rdata=0xFFFF_8001. req_ready is 0 from T+1 to T+5.
- SW at addr 0x0000_0006:
  - With LSU_MISALIGN_TRAP_EN: rsp at T+1, misalign=1, mem_we=0.
  - Without: mem_we=4'b1111, mem_addr=0x4.
- Non-memory request (both flags 0) followed immediately by an SW at 0x20:
  - First request: rsp at T+1, no strobes.
  - Second request is accepted only once state is IDLE (T+2).
  - mem_we=4'b1111 at T+3.
